// File: rtl/trans_pkg.sv
// Shared definitions for the transaction-layer traffic generator: state codes,
// data-mode encodings, default parameters and LFSR tap selection.
package trans_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_CFG   = 3'd1;
  localparam logic [STATE_W-1:0] ST_INIT  = 3'd2;
  localparam logic [STATE_W-1:0] ST_WAIT  = 3'd3;
  localparam logic [STATE_W-1:0] ST_PUSH  = 3'd4;
  localparam logic [STATE_W-1:0] ST_DRAIN = 3'd5;
  localparam logic [STATE_W-1:0] ST_DONE  = 3'd6;

  localparam logic [1:0] MODE_INC     = 2'b00;
  localparam logic [1:0] MODE_CONST   = 2'b01;
  localparam logic [1:0] MODE_LFSR    = 2'b10;
  localparam logic [1:0] MODE_INC_ALT = 2'b11;

  localparam int unsigned DATA_W_DEF       = 6;
  localparam int unsigned NUM_CH_DEF       = 2;
  localparam int unsigned BURST_MAX_DEF    = 16;
  localparam int unsigned DRAIN_CYCLES_DEF = 11;

  localparam logic [7:0] UMF_DEF_VAL = 8'h30;
  localparam logic [7:0] UVC_DEF_VAL = 8'hE0;
  localparam logic [7:0] UD_DEF_VAL  = 8'h30;

  // Maximal-length Fibonacci tap mask (bit i-1 set for tap x^i).
  function automatic logic [31:0] lfsr_taps(input int unsigned w);
    case (w)
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0E08;
      13:      return 32'h0000_1C80;
      14:      return 32'h0000_3802;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_D008;
      default: return 32'h0000_0003;
    endcase
  endfunction

endpackage

// File: rtl/tg_lfsr.sv
// Next-value logic for a Fibonacci LFSR; a zero seed is replaced by 1 so the
// register can never lock up in the all-zero state.
module tg_lfsr
  import trans_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              load,
  input  logic [DATA_W-1:0] seed,
  input  logic              step,
  input  logic [DATA_W-1:0] cur,
  output logic [DATA_W-1:0] nxt_c
);

  localparam logic [DATA_W-1:0] TAPS = DATA_W'(lfsr_taps(DATA_W));

  logic fb;

  always_comb begin
    fb    = ^(cur & TAPS);
    nxt_c = cur;
    if (load) begin
      nxt_c = (seed == '0) ? DATA_W'(1) : seed;
    end else if (step) begin
      nxt_c = {cur[DATA_W-2:0], fb};
    end
  end

endmodule

// File: rtl/trans_traffic_gen.sv
// Programmable reset/config/init/push/drain sequencer for the transaction layer.
// Define TG_ERR_ABORT_EN to cut a sequence short on error_in during PUSH/DRAIN.
module trans_traffic_gen
  import trans_pkg::*;
#(
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned NUM_CH       = NUM_CH_DEF,
  parameter int unsigned BURST_MAX    = BURST_MAX_DEF,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter logic [7:0]  UMF_DEF      = UMF_DEF_VAL,
  parameter logic [7:0]  UVC_DEF      = UVC_DEF_VAL,
  parameter logic [7:0]  UD_DEF       = UD_DEF_VAL
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [1:0]                       mode,
  input  logic [DATA_W-1:0]                seed,
  input  logic [$clog2(BURST_MAX+1)-1:0]   burst_len,
  input  logic [NUM_CH-1:0]                pop_mask,
  input  logic                             idle_in,
  input  logic                             error_in,
  output logic                             init,
  output logic [7:0]                       UMF,
  output logic [7:0]                       UVC,
  output logic [7:0]                       UD,
  output logic                             push_main,
  output logic [DATA_W-1:0]                data_in,
  output logic [NUM_CH-1:0]                pop,
  output logic                             busy,
  output logic                             done,
  output logic                             err_seen,
  output logic [15:0]                      push_count
);

  localparam int unsigned BL_W  = $clog2(BURST_MAX + 1);
  localparam int unsigned DR_W  = $clog2(DRAIN_CYCLES + 1);
  localparam int unsigned CNT_W = (BL_W > DR_W) ? BL_W : DR_W;

  logic [STATE_W-1:0] state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [1:0]         mode_q, mode_nxt;
  logic [DATA_W-1:0]  seed_q, seed_nxt;
  logic [BL_W-1:0]    blen_q, blen_nxt;
  logic [NUM_CH-1:0]  mask_q, mask_nxt;

  logic               init_nxt, push_nxt, busy_nxt, done_nxt, err_nxt;
  logic [7:0]         umf_nxt, uvc_nxt, ud_nxt;
  logic [DATA_W-1:0]  data_nxt;
  logic [NUM_CH-1:0]  pop_nxt;
  logic [15:0]        pcount_nxt;
  logic [DATA_W-1:0]  lfsr_nxt_c;

  // Loads the (guarded) seed on PUSH entry, steps on every further PUSH cycle.
  tg_lfsr #(.DATA_W(DATA_W)) u_lfsr (
    .load  (state != ST_PUSH),
    .seed  (seed_q),
    .step  (state == ST_PUSH),
    .cur   (data_in),
    .nxt_c (lfsr_nxt_c)
  );

  // Next-state and next-output decode; outputs are registered from state_nxt
  // so they line up with the state they belong to.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    mode_nxt   = mode_q;
    seed_nxt   = seed_q;
    blen_nxt   = blen_q;
    mask_nxt   = mask_q;
    init_nxt   = 1'b0;
    push_nxt   = 1'b0;
    done_nxt   = 1'b0;
    pop_nxt    = '0;
    umf_nxt    = UMF;
    uvc_nxt    = UVC;
    ud_nxt     = UD;
    data_nxt   = data_in;
    pcount_nxt = push_count;
    err_nxt    = err_seen | (error_in & (state != ST_IDLE));

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt  = ST_CFG;
          mode_nxt   = mode;
          seed_nxt   = seed;
          mask_nxt   = pop_mask;
          blen_nxt   = (burst_len > BL_W'(BURST_MAX)) ? BL_W'(BURST_MAX) : burst_len;
          err_nxt    = 1'b0;
          pcount_nxt = '0;
        end
      end
      ST_CFG:  state_nxt = ST_INIT;
      ST_INIT: begin
        state_nxt = ST_WAIT;
        cnt_nxt   = '0;
      end
      ST_WAIT: begin
        cnt_nxt = CNT_W'(1);
        if ((cnt != '0) && idle_in) begin
          if (blen_q != '0) begin
            state_nxt = ST_PUSH;
            cnt_nxt   = CNT_W'(blen_q - BL_W'(1));
          end else begin
            state_nxt = ST_DRAIN;
            cnt_nxt   = CNT_W'(DRAIN_CYCLES - 1);
          end
        end
      end
      ST_PUSH: begin
        if (cnt == '0) begin
          state_nxt = ST_DRAIN;
          cnt_nxt   = CNT_W'(DRAIN_CYCLES - 1);
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt == '0) begin
          state_nxt = ST_DONE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

`ifdef TG_ERR_ABORT_EN
    if (error_in && ((state == ST_PUSH) || (state == ST_DRAIN))) begin
      state_nxt = ST_DONE;
    end
`endif

    case (state_nxt)
      ST_CFG: begin
        umf_nxt = UMF_DEF;
        uvc_nxt = UVC_DEF;
        ud_nxt  = UD_DEF;
      end
      ST_INIT: init_nxt = 1'b1;
      ST_PUSH: begin
        push_nxt   = 1'b1;
        pop_nxt    = mask_q;
        pcount_nxt = push_count + 16'd1;
        if (state != ST_PUSH) begin
          data_nxt = (mode_q == MODE_LFSR) ? lfsr_nxt_c : seed_q;
        end else begin
          case (mode_q)
            MODE_INC, MODE_INC_ALT: data_nxt = data_in + DATA_W'(1);
            MODE_CONST:             data_nxt = data_in;
            MODE_LFSR:              data_nxt = lfsr_nxt_c;
            default:                data_nxt = data_in;
          endcase
        end
      end
      ST_DRAIN: pop_nxt  = mask_q;
      ST_DONE:  done_nxt = 1'b1;
      default:  ;
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
  end

  // State, captured configuration and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      mode_q     <= '0;
      seed_q     <= '0;
      blen_q     <= '0;
      mask_q     <= '0;
      init       <= 1'b0;
      UMF        <= '0;
      UVC        <= '0;
      UD         <= '0;
      push_main  <= 1'b0;
      data_in    <= '0;
      pop        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_seen   <= 1'b0;
      push_count <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      mode_q     <= mode_nxt;
      seed_q     <= seed_nxt;
      blen_q     <= blen_nxt;
      mask_q     <= mask_nxt;
      init       <= init_nxt;
      UMF        <= umf_nxt;
      UVC        <= uvc_nxt;
      UD         <= ud_nxt;
      push_main  <= push_nxt;
      data_in    <= data_nxt;
      pop        <= pop_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      err_seen   <= err_nxt;
      push_count <= pcount_nxt;
    end
  end

endmodule

// File: tb/tb_trans_traffic_gen.sv
// Directed bench for trans_traffic_gen with default parameters; honours
// TG_ERR_ABORT_EN in the same way as the design.
module tb_trans_traffic_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [5:0]  seed = 6'h00;
  logic [4:0]  burst_len = 5'd0;
  logic [1:0]  pop_mask = 2'b00;
  logic        idle_in = 1'b0;
  logic        error_in = 1'b0;
  logic        init;
  logic [7:0]  UMF, UVC, UD;
  logic        push_main;
  logic [5:0]  data_in;
  logic [1:0]  pop;
  logic        busy, done, err_seen;
  logic [15:0] push_count;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  localparam int DRAIN = 11;

  always #5 clk = ~clk;

  trans_traffic_gen dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .seed       (seed),
    .burst_len  (burst_len),
    .pop_mask   (pop_mask),
    .idle_in    (idle_in),
    .error_in   (error_in),
    .init       (init),
    .UMF        (UMF),
    .UVC        (UVC),
    .UD         (UD),
    .push_main  (push_main),
    .data_in    (data_in),
    .pop        (pop),
    .busy       (busy),
    .done       (done),
    .err_seen   (err_seen),
    .push_count (push_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, 32'({init, push_main, pop, busy, done, err_seen, data_in}), 32'd0);
    chk({tag, "_thr"}, 32'({UMF, UVC, UD}), 32'd0);
    chk({tag, "_cnt"}, 32'(push_count), 32'd0);
  endtask

  // Reference data sequence: x^6+x^5+1 Fibonacci LFSR, increment, constant.
  function automatic logic [5:0] model_next(input logic [1:0] m, input logic [5:0] w);
    case (m)
      2'b01:   return w;
      2'b10:   return {w[4:0], w[5] ^ w[4]};
      default: return w + 6'd1;
    endcase
  endfunction

  task automatic run_seq(input logic [1:0] m, input logic [5:0] s, input logic [4:0] bl,
                         input logic [1:0] msk, input int idle_delay, input int err_at,
                         input bit poke, output logic [5:0] nx);
    logic [5:0] w;
    logic [5:0] last;
    int         n;
    bit         aborted;
    n       = (bl > 5'd16) ? 16 : int'(bl);
    w       = (m == 2'b10 && s == 6'h00) ? 6'h01 : s;
    last    = w;
    aborted = 1'b0;
    mode = m; seed = s; burst_len = bl; pop_mask = msk;
    idle_in = (idle_delay == 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("cfg_busy", 32'(busy), 32'd1);
    chk("cfg_thr", 32'({UMF, UVC, UD}), 32'h30E030);
    chk("cfg_err_clr", 32'(err_seen), 32'd0);
    chk("cfg_cnt_clr", 32'(push_count), 32'd0);
    tick();
    chk("init_pulse", 32'(init), 32'd1);
    tick();
    chk("wait_init_low", 32'({init, push_main}), 32'd0);
    if (poke) begin
      start = 1'b1;
      seed  = ~s;
    end
    tick();
    start = 1'b0;
    chk("wait_min", 32'(push_main), 32'd0);
    for (int k = 0; k < idle_delay; k++) begin
      tick();
      chk("wait_idle", 32'({push_main, pop}), 32'd0);
    end
    idle_in = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      error_in = 1'b0;
`ifdef TG_ERR_ABORT_EN
      if (err_at != 0 && i == err_at) begin
        aborted = 1'b1;
        break;
      end
`endif
      chk("push_strobe", 32'(push_main), 32'd1);
      chk("push_data", 32'(data_in), 32'(w));
      chk("push_pop", 32'(pop), 32'(msk));
      chk("push_count", 32'(push_count), 32'(i + 1));
      if (err_at != 0 && i == err_at) chk("err_sticky", 32'(err_seen), 32'd1);
      last = w;
      w    = model_next(m, w);
      if (err_at != 0 && i == err_at - 1) error_in = 1'b1;
    end
    if (aborted) begin
      chk("abort_done", 32'({done, push_main, pop}), 32'b1000);
      chk("abort_count", 32'(push_count), 32'(err_at));
      chk("abort_err", 32'(err_seen), 32'd1);
    end else begin
      for (int d = 0; d < DRAIN; d++) begin
        tick();
        chk("drain_ctl", 32'({push_main, done, pop}), 32'(msk));
        if (n > 0) chk("drain_hold", 32'(data_in), 32'(last));
      end
      tick();
      chk("done_pulse", 32'({done, pop, busy}), 32'b1001);
      chk("done_count", 32'(push_count), 32'(n));
      chk("done_err", 32'(err_seen), (err_at != 0) ? 32'd1 : 32'd0);
      if (poke) start = 1'b1;
    end
    tick();
    start = 1'b0;
    chk("back_idle", 32'({busy, done}), 32'd0);
    nx = w;
  endtask

  initial begin
    logic [5:0] nx;

    #2 reset = 1'b0;
    #1 chk_all_zero("reset");
    tick();
    reset = 1'b1;
    tick();
    chk_all_zero("post_reset");

    // 1: increment burst of 13 from 0x27
    run_seq(2'b00, 6'h27, 5'd13, 2'b11, 0, 0, 1'b0, nx);
    // 2: zero-length burst, idle_in held low for a while
    run_seq(2'b00, 6'h05, 5'd0, 2'b01, 3, 0, 1'b0, nx);
    // 3: LFSR from seed 0, chained across 64 words (one burst clamped from 31)
    run_seq(2'b10, 6'h00, 5'd16, 2'b10, 0, 0, 1'b0, nx);
    run_seq(2'b10, nx, 5'd31, 2'b11, 0, 0, 1'b0, nx);
    run_seq(2'b10, nx, 5'd16, 2'b01, 0, 0, 1'b0, nx);
    run_seq(2'b10, nx, 5'd16, 2'b11, 0, 0, 1'b0, nx);
    // 4: wrap through 0x3F, start pokes during WAIT and DONE ignored
    run_seq(2'b00, 6'h3E, 5'd4, 2'b11, 0, 0, 1'b1, nx);
    run_seq(2'b11, 6'h3F, 5'd2, 2'b10, 0, 0, 1'b0, nx);
    run_seq(2'b01, 6'h15, 5'd3, 2'b01, 0, 0, 1'b0, nx);
    // 5: error pulse in PUSH cycle 3
    run_seq(2'b00, 6'h10, 5'd6, 2'b11, 0, 3, 1'b0, nx);

    // 6: reset asserted mid-DRAIN, then a normal run
    mode = 2'b00; seed = 6'h01; burst_len = 5'd2; pop_mask = 2'b11; idle_in = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    chk("mid_drain", 32'({push_main, pop}), 32'b011);
    #2 reset = 1'b0;
    #1 chk_all_zero("async_reset");
    tick();
    reset = 1'b1;
    tick();
    chk_all_zero("after_abort");
    run_seq(2'b00, 6'h20, 5'd3, 2'b11, 0, 0, 1'b0, nx);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
